// File: rtl/mmc3_irq_pkg.sv
// -----------------------------------------------------------------------------
// mmc3_irq_pkg
// Shared constants for the MMC3-compatible scanline IRQ controller.
//   REG_SEL_*      : register select codes forwarded by the mapper decoder
//   DEF_FILTER_CYC : default minimum A12-low run (m2 cycles) before an edge counts
//   DEF_CNT_W      : default scanline counter / latch width
// -----------------------------------------------------------------------------
package mmc3_irq_pkg;

    localparam logic [1:0] REG_SEL_LATCH   = 2'd0;  // $C000
    localparam logic [1:0] REG_SEL_RELOAD  = 2'd1;  // $C001
    localparam logic [1:0] REG_SEL_DISABLE = 2'd2;  // $E000
    localparam logic [1:0] REG_SEL_ENABLE  = 2'd3;  // $E001

    localparam int DEF_FILTER_CYC = 3;
    localparam int DEF_CNT_W      = 8;

    // Width of the A12 low-run counter; holds FILTER_CYCLES up to 15.
    localparam int LOW_CNT_W = 4;

endpackage

// File: rtl/mmc3_irq_ctrl_a12_edge_filter.sv
// -----------------------------------------------------------------------------
// a12_edge_filter
// Synchronises raw PPU A12 into the m2 domain and reports qualified rising
// edges: a 0->1 transition that follows at least FILTER_CYCLES consecutive
// synchronised-low cycles. Short low blips (sprite fetch noise) are ignored.
// Ports:
//   m2      : clock (CPU M2)
//   rst_n   : asynchronous active-low reset
//   ppu_a12 : raw A12, asynchronous to m2
//   qedge   : one-cycle qualified edge, consumed on the following m2 edge
//             (the counter update lands 3 m2 cycles after A12 rises at the pin)
// -----------------------------------------------------------------------------
module a12_edge_filter
    import mmc3_irq_pkg::*;
#(
    parameter int FILTER_CYCLES = DEF_FILTER_CYC
) (
    input  logic m2,
    input  logic rst_n,
    input  logic ppu_a12,
    output logic qedge
);

    localparam logic [LOW_CNT_W-1:0] FILT = LOW_CNT_W'(FILTER_CYCLES);

    logic                 sync1_reg;
    logic                 sync2_reg;
    logic                 dly_reg;
    logic [LOW_CNT_W-1:0] low_cnt_reg;

    always_ff @(posedge m2 or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg   <= 1'b0;
            sync2_reg   <= 1'b0;
            dly_reg     <= 1'b0;
            low_cnt_reg <= '0;
        end else begin
            sync1_reg <= ppu_a12;
            sync2_reg <= sync1_reg;
            dly_reg   <= sync2_reg;
            // Low-run counter saturates so a long low period still qualifies.
            if (sync2_reg) begin
                low_cnt_reg <= '0;
            end else if (low_cnt_reg != FILT) begin
                low_cnt_reg <= low_cnt_reg + 1'b1;
            end
        end
    end

    // low_cnt_reg still holds the length of the low run on the first high
    // cycle; it clears on the clock that consumes this edge.
    assign qedge = sync2_reg && !dly_reg && (low_cnt_reg >= FILT);

endmodule

// File: rtl/mmc3_irq_ctrl.sv
// -----------------------------------------------------------------------------
// mmc3_irq_ctrl
// MMC3-compatible scanline IRQ controller: filtered A12 edge counting,
// reload latch, enable/acknowledge and the IRQ output.
// Ports:
//   m2        : clock (CPU M2)
//   rst_n     : asynchronous active-low reset
//   ppu_a12   : raw PPU A12
//   reg_we    : one-cycle write strobe from the mapper register decoder
//   reg_sel   : 0 latch, 1 reload, 2 disable/ack, 3 enable
//   reg_data  : latch write data
//   irq_n     : registered IRQ, 0 = asserted (top level makes it open-drain)
//   irq_count : current counter value for readback
// Build option:
//   MMC3_ALT_IRQ_EN : rev A behaviour -- IRQ only on a decrement to 0 or on a
//                     pending reload of latch 0. Undefined = rev B, IRQ on any
//                     qualified edge leaving the counter at 0.
// -----------------------------------------------------------------------------
module mmc3_irq_ctrl
    import mmc3_irq_pkg::*;
#(
    parameter int FILTER_CYCLES = DEF_FILTER_CYC,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic             m2,
    input  logic             rst_n,
    input  logic             ppu_a12,
    input  logic             reg_we,
    input  logic [1:0]       reg_sel,
    input  logic [CNT_W-1:0] reg_data,
    output logic             irq_n,
    output logic [CNT_W-1:0] irq_count
);

    logic qedge;

    a12_edge_filter #(
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_filter (
        .m2      (m2),
        .rst_n   (rst_n),
        .ppu_a12 (ppu_a12),
        .qedge   (qedge)
    );

    logic [CNT_W-1:0] cnt_reg,   cnt_next;
    logic [CNT_W-1:0] latch_reg, latch_next;
    logic             rp_reg,    rp_next;
    logic             en_reg,    en_next;
    logic             pend_reg,  pend_next;
    logic             irq_n_reg;

    logic             wr_latch, wr_reload, wr_disable, wr_enable;
    logic [CNT_W-1:0] edge_cnt;
    logic             do_reload;
    logic             irq_hit;

    assign wr_latch   = reg_we && (reg_sel == REG_SEL_LATCH);
    assign wr_reload  = reg_we && (reg_sel == REG_SEL_RELOAD);
    assign wr_disable = reg_we && (reg_sel == REG_SEL_DISABLE);
    assign wr_enable  = reg_we && (reg_sel == REG_SEL_ENABLE);

    // Value the counter would take on a qualified edge. A zero count always
    // reloads, so the decrement can never wrap.
    assign do_reload = (cnt_reg == '0) || rp_reg;
    assign edge_cnt  = do_reload ? latch_reg : (cnt_reg - CNT_W'(1));

`ifdef MMC3_ALT_IRQ_EN
    // Rev A: a plain reload of latch 0 from an expired counter stays silent.
    assign irq_hit = (rp_reg && (latch_reg == '0)) ||
                     (!do_reload && (cnt_reg == CNT_W'(1)));
`else
    assign irq_hit = (edge_cnt == '0);
`endif

    always_comb begin
        cnt_next   = cnt_reg;
        latch_next = latch_reg;
        rp_next    = rp_reg;
        en_next    = en_reg;
        pend_next  = pend_reg;

        if (qedge) begin
            cnt_next = edge_cnt;
            if (do_reload) begin
                rp_next = 1'b0;
            end
            // An enable write on this same clock already counts as enabled.
            if (irq_hit && (en_reg || wr_enable)) begin
                pend_next = 1'b1;
            end
        end

        // Register writes come last so they override a coincident edge.
        if (wr_latch) begin
            latch_next = reg_data;
        end
        if (wr_reload) begin
            cnt_next = '0;
            rp_next  = 1'b1;
        end
        if (wr_disable) begin
            en_next   = 1'b0;
            pend_next = 1'b0;
        end
        if (wr_enable) begin
            en_next = 1'b1;
        end
    end

    always_ff @(posedge m2 or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg   <= '0;
            latch_reg <= '0;
            rp_reg    <= 1'b0;
            en_reg    <= 1'b0;
            pend_reg  <= 1'b0;
            irq_n_reg <= 1'b1;
        end else begin
            cnt_reg   <= cnt_next;
            latch_reg <= latch_next;
            rp_reg    <= rp_next;
            en_reg    <= en_next;
            pend_reg  <= pend_next;
            irq_n_reg <= ~pend_reg;
        end
    end

    assign irq_n     = irq_n_reg;
    assign irq_count = cnt_reg;

endmodule

// File: tb/tb_mmc3_irq_ctrl.sv
module tb_mmc3_irq_ctrl;

`ifdef MMC3_ALT_IRQ_EN
    localparam bit ALT = 1'b1;
`else
    localparam bit ALT = 1'b0;
`endif

    logic       m2 = 1'b0;
    logic       rst_n;
    logic       ppu_a12;
    logic       reg_we;
    logic [1:0] reg_sel;
    logic [7:0] reg_data;
    logic       irq_n;
    logic [7:0] irq_count;

    int total = 0;
    int bad   = 0;

    mmc3_irq_ctrl #(
        .FILTER_CYCLES (3),
        .CNT_W         (8)
    ) dut (
        .m2        (m2),
        .rst_n     (rst_n),
        .ppu_a12   (ppu_a12),
        .reg_we    (reg_we),
        .reg_sel   (reg_sel),
        .reg_data  (reg_data),
        .irq_n     (irq_n),
        .irq_count (irq_count)
    );

    always #5 m2 = ~m2;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       we;
        logic [1:0] sel;
        logic [7:0] data;
        int         lo;
        int         hi;
        int         reps;
        logic [7:0] exp_cnt;
        logic       exp_irq_n;
    } vec_t;

    vec_t vecs[$];

    task automatic tick();
        @(posedge m2);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write then one idle clock so irq_n (registered from irq_pend) settles.
    task automatic wr(input logic [1:0] sel, input logic [7:0] data);
        reg_we   = 1'b1;
        reg_sel  = sel;
        reg_data = data;
        tick();
        reg_we   = 1'b0;
        tick();
        $display("write sel=%0d data=%0d -> cnt=%0d irq_n=%0b", sel, data, irq_count, irq_n);
    endtask

    task automatic pulse(input int lo, input int hi);
        ppu_a12 = 1'b0;
        repeat (lo) tick();
        ppu_a12 = 1'b1;
        repeat (hi) tick();
    endtask

    // A12 pulse whose qualified-edge clock coincides with a register write.
    task automatic pulse_with_write(input logic [1:0] sel);
        ppu_a12 = 1'b0;
        repeat (8) tick();
        ppu_a12 = 1'b1;
        tick();
        tick();
        reg_we  = 1'b1;
        reg_sel = sel;
        tick();
        reg_we  = 1'b0;
        repeat (3) tick();
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] sel, input logic [7:0] data,
                                input int lo, input int hi, input int reps,
                                input logic [7:0] ec, input logic ei);
        vec_t v;
        v.we = we; v.sel = sel; v.data = data;
        v.lo = lo; v.hi = hi; v.reps = reps;
        v.exp_cnt = ec; v.exp_irq_n = ei;
        return v;
    endfunction

    initial begin
        rst_n    = 1'b0;
        ppu_a12  = 1'b0;
        reg_we   = 1'b0;
        reg_sel  = 2'd0;
        reg_data = 8'd0;

        // Basic countdown
        vecs.push_back(mk(1, 2'd0, 8'd3, 0, 0, 0, 8'd0, 1'b1));
        vecs.push_back(mk(1, 2'd1, 8'd0, 0, 0, 0, 8'd0, 1'b1));
        vecs.push_back(mk(1, 2'd3, 8'd0, 0, 0, 0, 8'd0, 1'b1));
        vecs.push_back(mk(0, 2'd0, 8'd0, 8, 4, 1, 8'd3, 1'b1));
        vecs.push_back(mk(0, 2'd0, 8'd0, 8, 4, 1, 8'd2, 1'b1));
        vecs.push_back(mk(0, 2'd0, 8'd0, 8, 4, 1, 8'd1, 1'b1));
        vecs.push_back(mk(0, 2'd0, 8'd0, 8, 4, 1, 8'd0, 1'b0));
        vecs.push_back(mk(0, 2'd0, 8'd0, 8, 4, 1, 8'd3, 1'b0));   // sticky pend
        vecs.push_back(mk(1, 2'd2, 8'd0, 0, 0, 0, 8'd3, 1'b1));   // ack
        // Glitch filter: 2 low cycles never qualify, 3 do
        vecs.push_back(mk(0, 2'd0, 8'd0, 2, 2, 10, 8'd3, 1'b1));
        vecs.push_back(mk(0, 2'd0, 8'd0, 3, 4, 1, 8'd2, 1'b1));
        // Enable gating
        vecs.push_back(mk(0, 2'd0, 8'd0, 8, 4, 1, 8'd1, 1'b1));
        vecs.push_back(mk(0, 2'd0, 8'd0, 8, 4, 1, 8'd0, 1'b1));
        vecs.push_back(mk(1, 2'd3, 8'd0, 0, 0, 0, 8'd0, 1'b1));
        vecs.push_back(mk(0, 2'd0, 8'd0, 8, 4, 1, 8'd3, 1'b1));
        vecs.push_back(mk(0, 2'd0, 8'd0, 8, 4, 1, 8'd2, 1'b1));
        vecs.push_back(mk(0, 2'd0, 8'd0, 8, 4, 1, 8'd1, 1'b1));
        vecs.push_back(mk(0, 2'd0, 8'd0, 8, 4, 1, 8'd0, 1'b0));
        vecs.push_back(mk(1, 2'd2, 8'd0, 0, 0, 0, 8'd0, 1'b1));
        // Latch = 0
        vecs.push_back(mk(1, 2'd0, 8'd0, 0, 0, 0, 8'd0, 1'b1));
        vecs.push_back(mk(1, 2'd3, 8'd0, 0, 0, 0, 8'd0, 1'b1));
        vecs.push_back(mk(1, 2'd1, 8'd0, 0, 0, 0, 8'd0, 1'b1));
        vecs.push_back(mk(0, 2'd0, 8'd0, 8, 4, 1, 8'd0, 1'b0));   // pending reload of 0
        vecs.push_back(mk(1, 2'd2, 8'd0, 0, 0, 0, 8'd0, 1'b1));
        vecs.push_back(mk(1, 2'd3, 8'd0, 0, 0, 0, 8'd0, 1'b1));
        vecs.push_back(mk(0, 2'd0, 8'd0, 8, 4, 1, 8'd0, ALT));    // plain reload of 0
        vecs.push_back(mk(1, 2'd2, 8'd0, 0, 0, 0, 8'd0, 1'b1));
        vecs.push_back(mk(1, 2'd3, 8'd0, 0, 0, 0, 8'd0, 1'b1));
        vecs.push_back(mk(0, 2'd0, 8'd0, 8, 4, 1, 8'd0, ALT));

        // Reset state
        tick();
        tick();
        chk("reset irq_n", 32'(irq_n), 32'd1);
        chk("reset irq_count", 32'(irq_count), 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].we) begin
                wr(vecs[i].sel, vecs[i].data);
            end
            for (int r = 0; r < vecs[i].reps; r++) begin
                pulse(vecs[i].lo, vecs[i].hi);
            end
            $display("vec %0d: cnt=%0d irq_n=%0b (exp %0d/%0b)", i, irq_count, irq_n,
                     vecs[i].exp_cnt, vecs[i].exp_irq_n);
            chk($sformatf("vec%0d cnt", i), 32'(irq_count), 32'(vecs[i].exp_cnt));
            chk($sformatf("vec%0d irq_n", i), 32'(irq_n), 32'(vecs[i].exp_irq_n));
        end

        // Disable write on the qedge clock that reaches 0
        wr(2'd2, 8'd0);
        wr(2'd0, 8'd1);
        wr(2'd1, 8'd0);
        wr(2'd3, 8'd0);
        pulse(8, 4);
        chk("dis setup cnt", 32'(irq_count), 32'd1);
        pulse_with_write(2'd2);
        tick();
        $display("disable on qedge: cnt=%0d irq_n=%0b", irq_count, irq_n);
        chk("dis qedge cnt", 32'(irq_count), 32'd0);
        chk("dis qedge irq_n", 32'(irq_n), 32'd1);

        // Reload write on a qedge clock
        wr(2'd0, 8'd5);
        wr(2'd1, 8'd0);
        pulse(8, 4);
        chk("rld setup cnt", 32'(irq_count), 32'd5);
        pulse_with_write(2'd1);
        $display("reload on qedge: cnt=%0d", irq_count);
        chk("rld qedge cnt", 32'(irq_count), 32'd0);
        pulse(8, 4);
        chk("rld next cnt", 32'(irq_count), 32'd5);
        chk("rld irq_n", 32'(irq_n), 32'd1);

        // Count down to IRQ, reload to 5, then async reset
        wr(2'd3, 8'd0);
        for (int k = 4; k >= 0; k--) begin
            pulse(8, 4);
            chk($sformatf("down%0d cnt", k), 32'(irq_count), 32'(k));
        end
        chk("down irq_n", 32'(irq_n), 32'd0);
        pulse(8, 4);
        chk("pre-rst cnt", 32'(irq_count), 32'd5);
        chk("pre-rst irq_n", 32'(irq_n), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        $display("async reset: cnt=%0d irq_n=%0b", irq_count, irq_n);
        chk("rst irq_n", 32'(irq_n), 32'd1);
        chk("rst cnt", 32'(irq_count), 32'd0);
        #1 rst_n = 1'b1;
        tick();
        pulse(8, 4);
        chk("post-rst cnt", 32'(irq_count), 32'd0);
        chk("post-rst irq_n", 32'(irq_n), 32'd1);
        wr(2'd3, 8'd0);
        pulse(8, 4);
        $display("post-reset enable: cnt=%0d irq_n=%0b", irq_count, irq_n);
        chk("post-en cnt", 32'(irq_count), 32'd0);
        chk("post-en irq_n", 32'(irq_n), 32'(ALT));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
